// File: rtl/gpp_pkg.sv
// Shared constants and types for the instruction fetch path.
package gpp_pkg;

  localparam int ADDR_W    = 9;
  localparam int INSTR_W   = 16;
  localparam int MEM_DEPTH = 400;

  // Fetch controller phases, in the order a program walks through them.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_VALID = 3'd4,
    ST_DONE  = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter with load/increment controls and the range compares
// the fetch FSM needs against the loaded program length.
module pc_reg #(
  parameter int ADDR_W = gpp_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] prog_len_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              last_o,
  output logic              target_ok_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  // Load wins over increment; a branch never coincides with a counted fetch.
  always_comb begin
    pc_d = pc_q;
    if (load_i)
      pc_d = load_val_i;
    else if (inc_i)
      pc_d = pc_q + ADDR_W'(1);
  end

  // PC state, cleared asynchronously with the rest of the fetch path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pc_q <= '0;
    else
      pc_q <= pc_d;
  end

  // pc < prog_len <= MEM_DEPTH < 2^ADDR_W, so pc+1 cannot wrap here.
  assign last_o      = ((pc_q + ADDR_W'(1)) == prog_len_i);
  assign target_ok_o = (target_i < prog_len_i);
  assign pc_o        = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch controller: sequences the program load into instruction memory,
// then fetches one instruction per request and hands it to the decoder
// over a valid/ready handshake. Owns pc, branch redirects and end-of-program.
module instr_fetch #(
  parameter int ADDR_W    = gpp_pkg::ADDR_W,
  parameter int INSTR_W   = gpp_pkg::INSTR_W,
  parameter int MEM_DEPTH = gpp_pkg::MEM_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               read_file,
  output logic               read_memory,
  output logic [ADDR_W-1:0]  pos,
  input  logic               fin_file,
  input  logic [INSTR_W-1:0] return_instr_line,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  prog_len,
  output logic               loaded,
  output logic               done,
  output logic               err
);
  import gpp_pkg::*;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

  fetch_state_e       state_q;
  logic [ADDR_W-1:0]  prog_len_q;
  logic [ADDR_W-1:0]  instr_pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               loaded_q, valid_q, done_q, err_q;

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_load_val;
  logic               pc_load, pc_inc, pc_last, tgt_ok;
  logic               active, load_exit, handshake, branch_act;

  // Strobes to memory and pc controls, all decoded from the current state.
  always_comb begin
    active      = (state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_VALID);
    load_exit   = fin_file || (prog_len_q == DEPTH_A);
    // Combinational so it drops in the very cycle fin_file is seen.
    read_file   = (state_q == ST_LOAD) && !fin_file && (prog_len_q < DEPTH_A);
    read_memory = (state_q == ST_REQ);
    handshake   = valid_q && instr_ready;
    branch_act  = active && branch_valid;
    // Out-of-range branches leave pc alone; the FSM goes to DONE instead.
    pc_load     = branch_act ? tgt_ok : ((state_q == ST_LOAD) && load_exit);
    pc_load_val = branch_act ? branch_target : '0;
    pc_inc      = (state_q == ST_VALID) && handshake && !branch_act;
  end

  pc_reg #(.ADDR_W(ADDR_W)) u_pc (
    .clk        (clk),
    .rst        (rst),
    .load_i     (pc_load),
    .load_val_i (pc_load_val),
    .inc_i      (pc_inc),
    .prog_len_i (prog_len_q),
    .target_i   (branch_target),
    .pc_o       (pc),
    .last_o     (pc_last),
    .target_ok_o(tgt_ok)
  );

  // Fetch FSM with registered decoder-side and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      prog_len_q <= '0;
      instr_pc_q <= '0;
      instr_q    <= '0;
      loaded_q   <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          // The line stored on this edge is counted, including the last one.
          if (read_file) prog_len_q <= prog_len_q + ADDR_W'(1);
          if (load_exit) begin
            loaded_q <= 1'b1;
            if (prog_len_q == '0) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_REQ;
            end
          end
        end
        ST_REQ, ST_WAIT, ST_VALID: begin
          if (branch_act) begin
            // Redirect beats the handshake; whatever is in flight is dropped.
            valid_q <= 1'b0;
            if (tgt_ok) begin
              state_q <= ST_REQ;
            end else begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end else if (state_q == ST_REQ) begin
            state_q <= ST_WAIT;
          end else if (state_q == ST_WAIT) begin
            instr_q    <= return_instr_line;
            instr_pc_q <= pc;
            valid_q    <= 1'b1;
            state_q    <= ST_VALID;
          end else if (handshake) begin
            valid_q <= 1'b0;
            if (pc_last) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_REQ;
            end
          end
        end
        ST_DONE: begin
          // Terminal until reset.
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pos         = pc;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign prog_len    = prog_len_q;
  assign loaded      = loaded_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: table of load/fetch scenarios run against a
// transaction-level scoreboard, plus directed multi-cycle corner cases.
module tb_instr_fetch;
  import gpp_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               instr_ready = 1'b0;
  logic               branch_valid = 1'b0;
  logic [ADDR_W-1:0]  branch_target = '0;
  logic               fin_file;
  logic [INSTR_W-1:0] return_instr_line;
  logic               read_file, read_memory, instr_valid, loaded, done, err;
  logic [ADDR_W-1:0]  pos, instr_pc, prog_len;
  logic [INSTR_W-1:0] instr;

  instr_fetch dut (
    .clk(clk), .rst(rst), .start(start),
    .read_file(read_file), .read_memory(read_memory), .pos(pos),
    .fin_file(fin_file), .return_instr_line(return_instr_line),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .prog_len(prog_len), .loaded(loaded), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // ---- memory + file model -------------------------------------------
  logic [INSTR_W-1:0] file_mem [0:511];
  logic [INSTR_W-1:0] mem      [0:511];
  int   file_len = 0;
  logic mem_clear = 1'b0;
  int   fptr, wr_idx, rf_cnt, rm_load, both_cnt;

  always @(posedge clk) begin
    if (mem_clear) begin
      fptr     <= 0;
      wr_idx   <= 0;
      fin_file <= (file_len == 0);
      rf_cnt   <= 0;
      rm_load  <= 0;
      both_cnt <= 0;
    end else begin
      if (read_file) begin
        mem[wr_idx] <= file_mem[fptr];
        wr_idx      <= wr_idx + 1;
        fptr        <= fptr + 1;
        fin_file    <= (fptr + 1 >= file_len);
        rf_cnt      <= rf_cnt + 1;
      end
      if (read_memory) begin
        return_instr_line <= mem[pos];
        if (!loaded) rm_load <= rm_load + 1;
      end
      if (read_file && read_memory) both_cnt <= both_cnt + 1;
    end
  end

  // ---- checking --------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fill_and_reset(input int len);
    rst = 1'b0;
    start = 1'b0;
    instr_ready = 1'b0;
    branch_valid = 1'b0;
    file_len = len;
    for (int i = 0; i < len; i++) file_mem[i] = INSTR_W'($urandom);
    mem_clear = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_clear = 1'b0;
    rst = 1'b1;
  endtask

  // Pulse start and wait for loaded; returns at the negedge loaded is first seen.
  task automatic do_load(input int exp_plen, input bit exp_done);
    int t;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!loaded && t < MEM_DEPTH + 20) begin
      @(negedge clk);
      t++;
    end
    chk("load_done", 32'(loaded), 1);
    chk("prog_len", 32'(prog_len), exp_plen);
    chk("read_file_edges", rf_cnt, exp_plen);
    chk("rm_during_load", rm_load, 0);
    chk("done_after_load", 32'(done), 32'(exp_done));
  endtask

  task automatic wait_valid(input string nm);
    int t = 0;
    @(negedge clk);
    while (!instr_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 32'(instr_valid), 1);
  endtask

  // Scoreboard: the program is a list; each accepted transfer must be the
  // next list element, a good branch moves the cursor, a bad one ends it.
  task automatic run_fetch(input int len, input int rdy_pct, input int br_pct);
    int mpc = 0, cyc = 0, rm_cyc = -100;
    bit mdone = 0, merr = 0, prev_v = 0, br, hs;
    logic [ADDR_W-1:0] tgt;
    while (!mdone && cyc < 4 * MEM_DEPTH + 400) begin
      chk("done_early", 32'(done), 0);
      if (instr_valid && !prev_v) chk("valid_latency", cyc - rm_cyc, 2);
      prev_v = instr_valid;
      if (read_memory) begin
        chk("pos", 32'(pos), mpc);
        rm_cyc = cyc;
      end
      br  = ($urandom_range(99) < br_pct);
      tgt = ADDR_W'($urandom_range(len + 1));
      instr_ready   = ($urandom_range(99) < rdy_pct);
      branch_valid  = br;
      branch_target = tgt;
      hs = instr_valid && instr_ready;
      if (br) begin
        if (int'(tgt) < len) mpc = int'(tgt);
        else begin merr = 1; mdone = 1; end
      end else if (hs) begin
        chk("instr_pc", 32'(instr_pc), mpc);
        chk("instr", 32'(instr), 32'(file_mem[mpc]));
        mpc++;
        if (mpc == len) mdone = 1;
      end
      cyc++;
      @(negedge clk);
    end
    instr_ready  = 1'b0;
    branch_valid = 1'b0;
    chk("fetch_timeout", 32'(mdone), 1);
    chk("done_end", 32'(done), 1);
    chk("err_end", 32'(err), 32'(merr));
    chk("valid_end", 32'(instr_valid), 0);
    chk("rm_end", 32'(read_memory), 0);
    if (rdy_pct == 100 && br_pct == 0) chk("throughput", cyc, 3 * len);
  endtask

  typedef struct {
    int len;
    int rdy;
    int br;
    int plen;
    bit dn;
  } vec_t;

  vec_t vt [7];

  initial begin
    logic [INSTR_W-1:0] hold_i;
    logic [ADDR_W-1:0]  hold_pc;
    int t;
    bit found;

    vt[0] = '{5,   100, 0,  5,   1'b0};
    vt[1] = '{0,   100, 0,  0,   1'b1};
    vt[2] = '{1,   100, 0,  1,   1'b0};
    vt[3] = '{7,   60,  0,  7,   1'b0};
    vt[4] = '{12,  70,  10, 12,  1'b0};
    vt[5] = '{9,   50,  20, 9,   1'b0};
    vt[6] = '{405, 100, 0,  400, 1'b0};

    // Reset values
    @(negedge clk);
    chk("rst_read_file", 32'(read_file), 0);
    chk("rst_read_memory", 32'(read_memory), 0);
    chk("rst_pos", 32'(pos), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_instr_pc", 32'(instr_pc), 0);
    chk("rst_prog_len", 32'(prog_len), 0);
    chk("rst_loaded", 32'(loaded), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);

    foreach (vt[i]) begin
      fill_and_reset(vt[i].len);
      do_load(vt[i].plen, vt[i].dn);
      if (vt[i].plen > 0) run_fetch(vt[i].plen, vt[i].rdy, vt[i].br);
      chk("strobe_overlap", both_cnt, 0);
    end

    // Backpressure: hold for 4 cycles, transfer on the ready cycle.
    fill_and_reset(5);
    do_load(5, 1'b0);
    instr_ready = 1'b0;
    wait_valid("bp_wait");
    chk("bp_instr", 32'(instr), 32'(file_mem[0]));
    chk("bp_pc", 32'(instr_pc), 0);
    hold_i  = instr;
    hold_pc = instr_pc;
    repeat (4) begin
      @(negedge clk);
      chk("bp_hold_instr", 32'(instr), 32'(hold_i));
      chk("bp_hold_pc", 32'(instr_pc), 32'(hold_pc));
      chk("bp_hold_valid", 32'(instr_valid), 1);
      chk("bp_no_rm", 32'(read_memory), 0);
      chk("bp_pc_still", 32'(pos), 0);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("bp_xfer_valid", 32'(instr_valid), 0);
    chk("bp_next_rm", 32'(read_memory), 1);
    chk("bp_next_pos", 32'(pos), 1);

    // Branch to 1 while fetching pc 3 (in WAIT).
    fill_and_reset(5);
    do_load(5, 1'b0);
    instr_ready = 1'b1;
    t = 0;
    found = 0;
    while (t < 40 && !found) begin
      if (read_memory && pos == 3) found = 1;
      else begin
        @(negedge clk);
        t++;
      end
    end
    chk("bw_found_req3", 32'(found), 1);
    @(negedge clk);
    branch_valid  = 1'b1;
    branch_target = ADDR_W'(1);
    @(negedge clk);
    branch_valid = 1'b0;
    chk("bw_dropped", 32'(instr_valid), 0);
    chk("bw_req", 32'(read_memory), 1);
    chk("bw_pos", 32'(pos), 1);
    wait_valid("bw_wait1");
    chk("bw_pc1", 32'(instr_pc), 1);
    chk("bw_instr1", 32'(instr), 32'(file_mem[1]));
    wait_valid("bw_wait2");
    chk("bw_pc2", 32'(instr_pc), 2);
    instr_ready = 1'b0;

    // Out-of-range branch coinciding with a handshake.
    fill_and_reset(5);
    do_load(5, 1'b0);
    instr_ready = 1'b1;
    wait_valid("bb_wait");
    branch_valid  = 1'b1;
    branch_target = ADDR_W'(5);
    @(negedge clk);
    branch_valid = 1'b0;
    instr_ready  = 1'b0;
    chk("bb_err", 32'(err), 1);
    chk("bb_done", 32'(done), 1);
    chk("bb_valid", 32'(instr_valid), 0);
    for (int k = 0; k < 6; k++) begin
      branch_valid  = 1'b1;
      branch_target = '0;
      start = (k % 2 == 0);
      @(negedge clk);
      chk("bb_no_rm", 32'(read_memory), 0);
      chk("bb_no_rf", 32'(read_file), 0);
      chk("bb_done_hold", 32'(done), 1);
      chk("bb_valid_hold", 32'(instr_valid), 0);
    end
    branch_valid = 1'b0;
    start = 1'b0;

    // Asynchronous reset while an instruction is presented.
    fill_and_reset(5);
    do_load(5, 1'b0);
    instr_ready = 1'b0;
    wait_valid("ar_wait");
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", 32'(instr_valid), 0);
    chk("ar_done", 32'(done), 0);
    chk("ar_loaded", 32'(loaded), 0);
    chk("ar_prog_len", 32'(prog_len), 0);
    chk("ar_pc", 32'(pos), 0);
    chk("ar_instr", 32'(instr), 0);
    @(negedge clk);
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch controller directly downstream of the instruction memory; drives its `read_file`, `read_memory` and `pos` inputs.
- Sequences the program-load phase, then fetches one 16-bit instruction per request from memory and hands it to the decoder with a valid/ready handshake.
- Owns the program counter, applies branch redirects from execute, and flags end-of-program.

Parameters:
- ADDR_W, 9, instruction address width; matches memory `pos`.
- INSTR_W, 16, instruction width.
- MEM_DEPTH, 400, number of memory entries; load stops here even without `fin_file`.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins program load.
- read_file  output  1  to memory: store next file line this edge.
- read_memory  output  1  to memory: read entry at `pos` this edge.
- pos  output  ADDR_W  to memory: fetch address, equals `pc` while `read_memory` is high.
- fin_file  input  1  from memory: file exhausted (registered in memory).
- return_instr_line  input  INSTR_W  from memory: data, valid the cycle after a `read_memory` edge.
- instr_valid  output  1  to decoder: `instr`/`instr_pc` valid.
- instr_ready  input  1  from decoder: accepts when high together with `instr_valid`.
- instr  output  INSTR_W  fetched instruction.
- instr_pc  output  ADDR_W  address of `instr`.
- branch_valid  input  1  from execute: redirect request.
- branch_target  input  ADDR_W  redirect address.
- prog_len  output  ADDR_W  number of lines loaded.
- loaded  output  1  load phase complete.
- done  output  1  program finished (pc reached `prog_len`).
- err  output  1  sticky: branch target at or beyond `prog_len`.

Behaviour:
- Reset (rst=0, async): state IDLE; pc=0; prog_len=0; all outputs 0; instr=0.
- IDLE:
  - `start` → LOAD.
  - Everything else is ignored.
- LOAD:
  - `read_file` = !fin_file && (prog_len < MEM_DEPTH). This is combinational, so it drops the same cycle `fin_file` is seen high and no extra line is stored.
  - `prog_len` increments on every edge with `read_file` high, so the final line stored together with `fin_file` is counted.
  - Exit when fin_file=1 or prog_len=MEM_DEPTH → `loaded`=1 (sticky until reset), pc=0, go to REQ.
  - If prog_len=0 at exit, go to DONE.
- REQ:
  - `read_memory`=1 and pos=pc for exactly one cycle → WAIT.
- WAIT:
  - Capture `return_instr_line` into `instr`, set instr_pc=pc and instr_valid=1 → VALID.
  - Latency from REQ entry to instr_valid: 2 cycles.
- VALID:
  - `instr`/`instr_pc` are held stable while instr_valid=1 and instr_ready=0.
  - On the handshake: pc=pc+1, instr_valid=0.
  - If pc+1 = prog_len → DONE; otherwise → REQ.
  - Throughput: one instruction per 3 cycles when ready is held high.
- DONE:
  - `done`=1; all memory strobes are 0.
  - Only reset leaves DONE. `start` is ignored.
- Branch (REQ/WAIT/VALID only; ignored in IDLE/LOAD/DONE):
  - `branch_valid` has priority over the handshake.
  - Any pending instruction is dropped: instr_valid=0 next cycle, and WAIT data is discarded.
  - If branch_target < prog_len: pc=target → REQ.
  - Otherwise: err=1 → DONE.
  - A branch in the same cycle as a handshake: the handshake is not counted and pc=target.
- pc arithmetic is ADDR_W unsigned. Wrap-around cannot occur because pc < prog_len ≤ MEM_DEPTH < 2^ADDR_W.
- read_file and read_memory are never high together.
- Reset mid-LOAD: memory contents are undefined to this block. A fresh `start` reloads from the current file position, and that is the accepted behaviour.

Decomposition:
- Shared package `gpp_pkg`:
  - ADDR_W, INSTR_W, MEM_DEPTH constants.
  - Fetch state enum {IDLE, LOAD, REQ, WAIT, VALID, DONE}.
- Sub-module `pc_reg`: holds pc with load (branch/reset-to-0) and increment controls, plus the range compare against `prog_len`.
- FSM and output logic stay in `instr_fetch`.

Test Plan:
- 5-line file:
  - Stimulus: start pulse.
  - Required: read_file high for exactly 5 edges; prog_len=5; loaded=1; no read_memory during LOAD.
- Sequential fetch, ready tied high:
  - Required: instr_pc sequence 0,1,2,3,4, each valid 2 cycles after its read_memory strobe; instr matches file lines; done=1 after pc 4 accepted.
- Backpressure:
  - Stimulus: ready=0 for 4 cycles while valid.
  - Required: instr and instr_pc stable, no new read_memory, pc unchanged; the transfer completes on the cycle ready=1.
- Branch during WAIT:
  - Stimulus: branch_target=1 while fetching pc=3.
  - Required: pc 3 data never presented; next instr_pc=1, then 2.
- Bad branch:
  - Stimulus: branch_target=5 with prog_len=5.
  - Required: err=1, done=1, no further strobes; branch ignored afterwards.
- Async reset mid-VALID:
  - Stimulus: rst low between clock edges.
  - Required: instr_valid, done and loaded drop immediately; pc=0 and prog_len=0.
